// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the execute-stage sequencer: FSM states, condition codes,
// decode classes and the opcodes the sequencer itself interprets.
package ex_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] LD_REG    = 2'b00;
    localparam logic [1:0] LD_BRANCH = 2'b10;
    localparam logic [1:0] LD_SYS    = 2'b11;

    localparam logic [2:0] OP_B     = 3'b000;
    localparam logic [2:0] OP_BCOND = 3'b001;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Bit positions of the flags inside cpsr / alu_flags.
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    function automatic logic writes_reg(input logic special_encoding,
                                        input logic [1:0] first_ld);
        return special_encoding || (first_ld == LD_REG);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: decides whether b_cond holds for
// the given N,C,Z,V flag set.
module cond_eval
    import ex_ctrl_pkg::*;
(
    input  logic [3:0] b_cond,
    input  logic [3:0] cpsr,
    output logic       take
);

    logic n, c, z, v;

    assign n = cpsr[FLAG_N];
    assign c = cpsr[FLAG_C];
    assign z = cpsr[FLAG_Z];
    assign v = cpsr[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (b_cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !(c && !z);
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = !(!z && (n == v));
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC and CPSR,
// resolving branches and gating the register-file write strobe.
module ex_sequencer
    import ex_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH      = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
    parameter int                  FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ir_load,
    input  logic [1:0]          first_ld,
    input  logic                special_encoding,
    input  logic [2:0]          alu_oc,
    input  logic                set_flags,
    input  logic [3:0]          b_cond,
    input  logic [15:0]         offset,
    input  logic [3:0]          alu_flags,
    output logic                reg_w_enable,
    output logic [3:0]          cpsr,
    output logic                branch_taken,
    output logic                halted,
    output logic                fetch_fault
);

    localparam int CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_t              state_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [3:0]          cpsr_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic                fault_reg;

    logic                cond_take;
    logic                is_branch;
    logic                is_halt;
    logic                branch_go;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] pc_next;

    cond_eval u_cond_eval (
        .b_cond (b_cond),
        .cpsr   (cpsr_reg),
        .take   (cond_take)
    );

    // Size cast of a signed value sign-extends when widening, truncates when narrowing.
    assign offset_ext = PC_WIDTH'($signed(offset));

    assign is_branch = !special_encoding && (first_ld == LD_BRANCH);
    assign is_halt   = !special_encoding && (first_ld == LD_SYS) && (alu_oc == OP_HALT);
    assign branch_go = is_branch &&
                       ((alu_oc == OP_B) || ((alu_oc == OP_BCOND) && cond_take));
    assign pc_next   = branch_go ? (pc_reg + offset_ext) : (pc_reg + PC_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            cpsr_reg     <= 4'b0000;
            wait_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ack) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= DECODE;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        wait_cnt_reg <= '0;
                        fault_reg    <= 1'b1;
                        state_reg    <= HALT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                DECODE: begin
                    state_reg <= EXECUTE;
                end
                EXECUTE: begin
                    if (special_encoding && set_flags) begin
                        cpsr_reg <= alu_flags;
                    end
                    state_reg <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (is_halt) begin
                        state_reg <= HALT;
                    end else begin
                        pc_reg    <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    // Strobes are masked while rst is high so nothing leaks out during reset.
    assign imem_req     = !rst && (state_reg == FETCH);
    assign ir_load      = !rst && (state_reg == FETCH) && imem_ack;
    assign reg_w_enable = !rst && (state_reg == WRITEBACK) &&
                          writes_reg(special_encoding, first_ld);
    assign branch_taken = !rst && (state_reg == WRITEBACK) && branch_go;
    assign halted       = !rst && (state_reg == HALT);
    assign fetch_fault  = fault_reg;
    assign pc           = pc_reg;
    assign cpsr         = cpsr_reg;

endmodule

// File: tb/tb_ex_sequencer.sv
// Directed bench for ex_sequencer: vector table of instructions plus hand-written
// reset, timeout, halt and wrap sequences; standalone sweep of cond_eval.
module tb_ex_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] pc;
    logic        ir_load;
    logic [1:0]  first_ld = 2'b00;
    logic        special_encoding = 1'b0;
    logic [2:0]  alu_oc = 3'b000;
    logic        set_flags = 1'b0;
    logic [3:0]  b_cond = 4'b0000;
    logic [15:0] offset = 16'h0000;
    logic [3:0]  alu_flags = 4'b0000;
    logic        reg_w_enable;
    logic [3:0]  cpsr;
    logic        branch_taken;
    logic        halted;
    logic        fetch_fault;

    logic [3:0]  ce_cond = 4'b0000;
    logic [3:0]  ce_cpsr = 4'b0000;
    logic        ce_take;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000), .FETCH_TIMEOUT(15)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_ack         (imem_ack),
        .pc               (pc),
        .ir_load          (ir_load),
        .first_ld         (first_ld),
        .special_encoding (special_encoding),
        .alu_oc           (alu_oc),
        .set_flags        (set_flags),
        .b_cond           (b_cond),
        .offset           (offset),
        .alu_flags        (alu_flags),
        .reg_w_enable     (reg_w_enable),
        .cpsr             (cpsr),
        .branch_taken     (branch_taken),
        .halted           (halted),
        .fetch_fault      (fetch_fault)
    );

    cond_eval u_ce (
        .b_cond (ce_cond),
        .cpsr   (ce_cpsr),
        .take   (ce_take)
    );

    typedef struct {
        logic        se;
        logic [1:0]  ld;
        logic [2:0]  oc;
        logic        sf;
        logic [3:0]  bc;
        logic [15:0] off;
        logic [3:0]  af;
        logic [15:0] exp_pc;
        logic [3:0]  exp_cpsr;
        logic        exp_wen;
        logic        exp_tk;
        logic        exp_halt;
    } vec_t;

    function automatic vec_t mk(logic se, logic [1:0] ld, logic [2:0] oc, logic sf,
                                logic [3:0] bc, logic [15:0] off, logic [3:0] af,
                                logic [15:0] epc, logic [3:0] ecpsr, logic ewen,
                                logic etk, logic ehalt);
        vec_t v;
        v.se = se; v.ld = ld; v.oc = oc; v.sf = sf; v.bc = bc; v.off = off; v.af = af;
        v.exp_pc = epc; v.exp_cpsr = ecpsr; v.exp_wen = ewen; v.exp_tk = etk;
        v.exp_halt = ehalt;
        return v;
    endfunction

    // Reference condition model: base test selected by cond[3:1], inverted by cond[0].
    function automatic logic cc_model(logic [3:0] c, logic [3:0] f);
        logic n, cy, z, v, b;
        n = f[3]; cy = f[2]; z = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies reset for one clock edge, checks the reset state, releases at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_irl", ir_load, 0);
        check("rst_wen", reg_w_enable, 0);
        check("rst_tk", branch_taken, 0);
        check("rst_halt", halted, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_cpsr", cpsr, 4'h0);
        rst = 1'b0;
        #1;
        check("rst_req_after", imem_req, 1);
        $display("reset: pc=%0h cpsr=%0h req=%0b", pc, cpsr, imem_req);
    endtask

    task automatic run_instr(input vec_t v, input string tag);
        int waited;
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_req_wait"}, imem_req, 1);
        if (imem_req) begin
            special_encoding = v.se; first_ld = v.ld; alu_oc = v.oc; set_flags = v.sf;
            b_cond = v.bc; offset = v.off; alu_flags = v.af;
            imem_ack = 1'b1;
            #1;
            check({tag, "_irload"}, ir_load, 1);
            @(negedge clk);
            imem_ack = 1'b0;
            check({tag, "_dec_irl"}, ir_load, 0);
            check({tag, "_dec_wen"}, reg_w_enable, 0);
            check({tag, "_dec_req"}, imem_req, 0);
            @(negedge clk);
            check({tag, "_ex_wen"}, reg_w_enable, 0);
            check({tag, "_ex_tk"}, branch_taken, 0);
            @(negedge clk);
            check({tag, "_wb_wen"}, reg_w_enable, v.exp_wen);
            check({tag, "_wb_tk"}, branch_taken, v.exp_tk);
            check({tag, "_wb_irl"}, ir_load, 0);
            @(negedge clk);
            check({tag, "_pc"}, pc, v.exp_pc);
            check({tag, "_cpsr"}, cpsr, v.exp_cpsr);
            check({tag, "_halt"}, halted, v.exp_halt);
            check({tag, "_req"}, imem_req, !v.exp_halt);
            $display("%s: pc=%0h cpsr=%0h wen=%0b tk=%0b halt=%0b",
                     tag, pc, cpsr, v.exp_wen, v.exp_tk, halted);
        end
    endtask

    vec_t tbl[21];

    initial begin
        // se ld oc sf bc off af | exp_pc cpsr wen tk halt
        tbl[0]  = mk(1, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'hF, 16'h0001, 4'h0, 1, 0, 0);
        tbl[1]  = mk(0, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'h0, 16'h0002, 4'h0, 1, 0, 0);
        tbl[2]  = mk(0, 2'b01, 3'b000, 0, 4'h0, 16'h0000, 4'h0, 16'h0003, 4'h0, 0, 0, 0);
        tbl[3]  = mk(0, 2'b10, 3'b000, 0, 4'h0, 16'h0002, 4'h0, 16'h0005, 4'h0, 0, 1, 0);
        tbl[4]  = mk(1, 2'b00, 3'b000, 1, 4'h0, 16'h0000, 4'h2, 16'h0006, 4'h2, 1, 0, 0);
        tbl[5]  = mk(0, 2'b10, 3'b001, 0, 4'h0, 16'hFFFD, 4'h0, 16'h0003, 4'h2, 0, 1, 0);
        tbl[6]  = mk(0, 2'b10, 3'b001, 0, 4'hF, 16'h0005, 4'h0, 16'h0004, 4'h2, 0, 0, 0);
        tbl[7]  = mk(0, 2'b10, 3'b001, 0, 4'h1, 16'h0005, 4'h0, 16'h0005, 4'h2, 0, 0, 0);
        tbl[8]  = mk(1, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'hF, 16'h0006, 4'h2, 1, 0, 0);
        tbl[9]  = mk(0, 2'b00, 3'b000, 1, 4'h0, 16'h0000, 4'hF, 16'h0007, 4'h2, 1, 0, 0);
        tbl[10] = mk(0, 2'b10, 3'b001, 0, 4'h2, 16'h0000, 4'h0, 16'h0008, 4'h2, 0, 0, 0);
        tbl[11] = mk(1, 2'b00, 3'b000, 1, 4'h0, 16'h0000, 4'h9, 16'h0009, 4'h9, 1, 0, 0);
        tbl[12] = mk(0, 2'b10, 3'b001, 0, 4'hA, 16'h0000, 4'h0, 16'h0009, 4'h9, 0, 1, 0);
        tbl[13] = mk(0, 2'b10, 3'b001, 0, 4'hB, 16'h0003, 4'h0, 16'h000A, 4'h9, 0, 0, 0);
        tbl[14] = mk(0, 2'b10, 3'b001, 0, 4'h8, 16'h0004, 4'h0, 16'h000B, 4'h9, 0, 0, 0);
        tbl[15] = mk(0, 2'b10, 3'b010, 0, 4'hE, 16'h0004, 4'h0, 16'h000C, 4'h9, 0, 0, 0);
        tbl[16] = mk(0, 2'b10, 3'b001, 0, 4'hE, 16'h8000, 4'h0, 16'h800C, 4'h9, 0, 1, 0);
        tbl[17] = mk(1, 2'b00, 3'b000, 1, 4'h0, 16'h0000, 4'h4, 16'h800D, 4'h4, 1, 0, 0);
        tbl[18] = mk(0, 2'b10, 3'b001, 0, 4'h9, 16'h0002, 4'h0, 16'h800E, 4'h4, 0, 0, 0);
        tbl[19] = mk(0, 2'b10, 3'b001, 0, 4'hC, 16'hFFF1, 4'h0, 16'h7FFF, 4'h4, 0, 1, 0);
        tbl[20] = mk(0, 2'b11, 3'b110, 0, 4'h0, 16'h0000, 4'h0, 16'h8000, 4'h4, 0, 0, 0);

        // Standalone condition evaluator sweep.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                ce_cond = 4'(c);
                ce_cpsr = 4'(f);
                #1;
                check("cond", ce_take, cc_model(4'(c), 4'(f)));
            end
        end
        $display("cond_eval sweep: 256 combinations");

        do_reset();
        for (int i = 0; i < 21; i++) begin
            run_instr(tbl[i], $sformatf("vec%0d", i));
        end

        // Same branch sequence without set_flags: EQ falls through.
        do_reset();
        run_instr(mk(0, 2'b10, 3'b000, 0, 4'h0, 16'h0005, 4'h0, 16'h0005, 4'h0, 0, 1, 0), "nf_b5");
        run_instr(mk(1, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'h2, 16'h0006, 4'h0, 1, 0, 0), "nf_alu");
        run_instr(mk(0, 2'b10, 3'b001, 0, 4'h0, 16'hFFFD, 4'h0, 16'h0007, 4'h0, 0, 0, 0), "nf_eq");

        // PC wrap and large negative offset.
        do_reset();
        run_instr(mk(0, 2'b10, 3'b000, 0, 4'h0, 16'hFFFF, 4'h0, 16'hFFFF, 4'h0, 0, 1, 0), "wr_to_ffff");
        run_instr(mk(0, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1, 0, 0), "wr_wrap");
        run_instr(mk(0, 2'b10, 3'b000, 0, 4'h0, 16'h0002, 4'h0, 16'h0002, 4'h0, 0, 1, 0), "wr_to2");
        run_instr(mk(0, 2'b10, 3'b001, 0, 4'hE, 16'h8000, 4'h0, 16'h8002, 4'h0, 0, 1, 0), "wr_8000");

        // Halt instruction: pc frozen, ack ignored, no requests.
        do_reset();
        run_instr(mk(0, 2'b10, 3'b000, 0, 4'h0, 16'h0009, 4'h0, 16'h0009, 4'h0, 0, 1, 0), "h_to9");
        run_instr(mk(0, 2'b11, 3'b111, 0, 4'h0, 16'h0004, 4'h0, 16'h0009, 4'h0, 0, 0, 1), "h_halt");
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("halt_stay", halted, 1);
            check("halt_req", imem_req, 0);
            check("halt_pc", pc, 16'h0009);
            check("halt_irl", ir_load, 0);
        end
        imem_ack = 1'b0;
        $display("halt hold: pc=%0h halted=%0b", pc, halted);

        // Fetch timeout, then recovery through reset.
        do_reset();
        repeat (14) @(negedge clk);
        check("to_nofault14", fetch_fault, 0);
        check("to_req14", imem_req, 1);
        @(negedge clk);
        check("to_fault", fetch_fault, 1);
        check("to_halted", halted, 1);
        check("to_req", imem_req, 0);
        repeat (3) @(negedge clk);
        check("to_sticky", fetch_fault, 1);
        $display("timeout: fault=%0b halted=%0b req=%0b", fetch_fault, halted, imem_req);
        do_reset();
        run_instr(mk(0, 2'b00, 3'b000, 0, 4'h0, 16'h0000, 4'h0, 16'h0001, 4'h0, 1, 0, 0), "to_recover");

        // Reset landing in EXECUTE wins over a pending flag update.
        do_reset();
        run_instr(mk(1, 2'b00, 3'b000, 1, 4'h0, 16'h0000, 4'hF, 16'h0001, 4'hF, 1, 0, 0), "mx_setf");
        special_encoding = 1'b1; set_flags = 1'b1; alu_flags = 4'hA; first_ld = 2'b00;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mx_cpsr", cpsr, 4'h0);
        check("mx_pc", pc, 16'h0000);
        check("mx_req_rst", imem_req, 0);
        rst = 1'b0;
        #1;
        check("mx_req_after", imem_req, 1);
        $display("mid-execute reset: pc=%0h cpsr=%0h", pc, cpsr);
        run_instr(mk(0, 2'b10, 3'b001, 0, 4'h0, 16'h0007, 4'h0, 16'h0001, 4'h0, 0, 0, 0), "mx_eq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_sequencer.md
Name: ex_sequencer

Overview:
- Multi-cycle control FSM that sequences the execute datapath: FETCH -> DECODE -> EXECUTE -> WRITEBACK, one instruction at a time.
- Owns the program counter and the CPSR flag register (N,C,Z,V).
- Evaluates branch conditions and gates the register-file write enable.
- Sits between instruction memory, the decoder outputs and the EX/ALU stage.

Parameters:
- PC_WIDTH, 16, width of the program counter (word-addressed).
- RESET_PC, 0, PC value loaded on reset.
- FETCH_TIMEOUT, 15, max cycles to wait for imem_ack before faulting (>=1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction word valid this cycle
- pc  out  PC_WIDTH  current instruction address
- ir_load  out  1  one-cycle pulse: decoder latches instruction word
- first_ld  in  2  first-level decode class
- special_encoding  in  1  1 = ALU instruction
- alu_oc  in  3  operation command
- set_flags  in  1  second-level decode bit 3: update CPSR
- b_cond  in  4  branch condition code
- offset  in  16  signed branch offset, in words
- alu_flags  in  4  N,C,Z,V computed by EX for the current instruction
- reg_w_enable  out  1  register-file write strobe
- cpsr  out  4  registered flags N,C,Z,V (bit 3..0)
- branch_taken  out  1  pulse in WRITEBACK when the PC is redirected
- halted  out  1  high while in HALT
- fetch_fault  out  1  sticky; set on fetch timeout

Behaviour:
- Reset (rst=1 at an edge, in any state): state=FETCH, pc=RESET_PC, cpsr=0, wait counter=0, fetch_fault=0. All outputs low except pc. The first imem_req is asserted in the cycle after rst deasserts.
- FETCH:
  - imem_req=1; the counter increments each cycle without ack.
  - imem_ack=1: ir_load=1 in the same cycle, counter clears, next state DECODE.
  - Counter reaches FETCH_TIMEOUT without ack: fetch_fault=1, next state HALT.
  - imem_ack outside FETCH is ignored.
- DECODE: one cycle, no outputs; the decoder settles.
- EXECUTE: one cycle. If special_encoding & set_flags, cpsr <= alu_flags at the end of this cycle. Otherwise cpsr holds.
- WRITEBACK: one cycle.
  - reg_w_enable=1 iff special_encoding=1, or (special_encoding=0 & first_ld=2'b00).
  - Branch class: special_encoding=0 & first_ld=2'b10.
    - alu_oc=000: unconditional branch.
    - alu_oc=001: conditional on b_cond.
  - Taken: pc <= pc + sext(offset), truncated to PC_WIDTH (wraps mod 2^PC_WIDTH); branch_taken=1. Otherwise pc <= pc+1, which also wraps.
  - Halt instruction (special_encoding=0 & first_ld=2'b11 & alu_oc=3'b111): pc is not advanced, next state HALT. All other cases go to FETCH.
- HALT: halted=1, no requests, pc and cpsr frozen. Only rst exits.
- Instruction latency: 4 cycles with a zero-wait fetch (ack in the first FETCH cycle).
- Condition codes are evaluated against the registered cpsr (flags from prior instructions):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !(C & !Z)
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: !(!Z & (N==V))
  - 1110 AL: 1
  - 1111 NV: 0 (nop)
- Offset 0 taken: pc unchanged (legal self-loop).
- Flags with set_flags=0, or on non-ALU instructions, never change.

Decomposition:
- Package ex_ctrl_pkg:
  - state enum {FETCH, DECODE, EXECUTE, WRITEBACK, HALT}
  - condition-code constants (COND_EQ..COND_NV)
  - first_ld class constants (LD_REG=00, LD_BRANCH=10, LD_SYS=11)
  - HALT opcode constant
- Sub-module cond_eval (combinational): inputs b_cond, cpsr; output take. It is verified standalone across all 16x16 combinations.

Test Plan:
- Reset then ack on every request: pc sequence 0,1,2 every 4 cycles; ir_load is one pulse per instruction; reg_w_enable pulses only in WRITEBACK for ALU/first_ld=00.
- ALU with set_flags=1, alu_flags=4'b0010, at pc=5; then Bcond b_cond=0000 (EQ), offset=-3 -> cpsr=0010; branch_taken=1; next pc=3.
- Same sequence with set_flags=0 (cpsr stays 0000) -> EQ not taken, pc=7. Separately, b_cond=1111 with any cpsr -> never taken.
- PC_WIDTH=16, pc=16'hFFFF, non-branch -> pc=0. pc=2, offset=16'h8000 taken -> pc=16'h8002.
- imem_ack withheld for 15 cycles -> fetch_fault=1, halted=1, imem_req=0. rst for one cycle -> pc=RESET_PC, fault cleared, imem_req=1 the cycle after rst falls.
- Halt instruction at pc=9 -> halted=1, pc stays 9, no further imem_req. rst asserted mid-EXECUTE of another run -> cpsr=0, state FETCH.
